// File: rtl/hello_tx.sv
// Byte-stream source for the hello detector: emits "hello" repeat_cnt times over a
// valid/ready link, with optional idle gaps and optional corruption of the very last byte.
module hello_tx #(
   parameter int unsigned GAP_CYCLES = 0
) (
   input  logic       sys_clk,
   input  logic       reset_n,
   input  logic       start,
   input  logic [7:0] repeat_cnt,
   input  logic       err_en,
   input  logic       abort,
   input  logic       data_out_ready,
   output logic [7:0] data_out,
   output logic       data_out_valid,
   output logic       busy,
   output logic       done,
   output logic [7:0] words_sent
);

   typedef enum logic [6:0] {
      IDLE    = 7'b0000001,
      SEND_H  = 7'b0000010,
      SEND_E  = 7'b0000100,
      SEND_L1 = 7'b0001000,
      SEND_L2 = 7'b0010000,
      SEND_O  = 7'b0100000,
      GAP     = 7'b1000000
   } state_t;

   // Gap counter runs GAP_CYCLES-1 down to 0, so it never needs to hold GAP_CYCLES itself.
   localparam int unsigned GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

   state_t          state_q, state_d;
   state_t          ret_q, ret_d;
   logic [GW-1:0]   gap_q, gap_d;
   logic [7:0]      rem_q, rem_d;
   logic            err_q, err_d;
   logic [7:0]      words_q, words_d;
   logic [7:0]      data_q, data_d;
   logic            valid_q, valid_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic            fin;
   logic            accept;
   logic            last_word;

   assign accept    = valid_q & data_out_ready;
   assign last_word = (rem_q == 8'd1);

   function automatic state_t succ(input state_t s);
      case (s)
         SEND_H:  return SEND_E;
         SEND_E:  return SEND_L1;
         SEND_L1: return SEND_L2;
         SEND_L2: return SEND_O;
         SEND_O:  return SEND_H;
         default: return IDLE;
      endcase
   endfunction

   // The final "o" of the run becomes "O" when error injection was latched.
   function automatic logic [7:0] char_of(input state_t s, input logic final_err);
      case (s)
         SEND_H:  return 8'h68;
         SEND_E:  return 8'h65;
         SEND_L1: return 8'h6C;
         SEND_L2: return 8'h6C;
         SEND_O:  return final_err ? 8'h4F : 8'h6F;
         default: return 8'h00;
      endcase
   endfunction

   always_ff @(posedge sys_clk) begin
      if (!reset_n) begin
         state_q <= IDLE;
         ret_q   <= IDLE;
         gap_q   <= '0;
         rem_q   <= 8'd0;
         err_q   <= 1'b0;
         words_q <= 8'd0;
         data_q  <= 8'h00;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ret_q   <= ret_d;
         gap_q   <= gap_d;
         rem_q   <= rem_d;
         err_q   <= err_d;
         words_q <= words_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      ret_d   = ret_q;
      gap_d   = gap_q;
      rem_d   = rem_q;
      err_d   = err_q;
      words_d = words_q;
      fin     = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               rem_d   = (repeat_cnt == 8'd0) ? 8'd1 : repeat_cnt;
               err_d   = err_en;
               words_d = 8'd0;
               state_d = SEND_H;
            end
         end
         GAP: begin
            if (gap_q == '0) state_d = ret_q;
            else             gap_d   = gap_q - 1'b1;
         end
         default: begin
            if (accept) begin
               if (state_q == SEND_O) begin
                  if (words_q != 8'hFF) words_d = words_q + 8'd1;
                  rem_d = rem_q - 8'd1;
               end
               if (state_q == SEND_O && last_word) begin
                  state_d = IDLE;
                  fin     = 1'b1;
               end else if (GAP_CYCLES > 0) begin
                  state_d = GAP;
                  ret_d   = succ(state_q);
                  gap_d   = GW'(GAP_CYCLES - 1);
               end else begin
                  state_d = succ(state_q);
               end
            end
         end
      endcase
      // Abort still lets a same-cycle acceptance count, but suppresses done.
      if (abort && state_q != IDLE) begin
         state_d = IDLE;
         fin     = 1'b0;
      end
   end

   always_comb begin
      valid_d = state_d inside {SEND_H, SEND_E, SEND_L1, SEND_L2, SEND_O};
      busy_d  = (state_d != IDLE);
      done_d  = fin;
      data_d  = valid_d ? char_of(state_d, err_d && rem_d == 8'd1) : data_q;
   end

   assign data_out       = data_q;
   assign data_out_valid = valid_q;
   assign busy           = busy_q;
   assign done           = done_q;
   assign words_sent     = words_q;

endmodule

// File: doc/hello_tx.md
# hello_tx

Byte-stream transmitter that emits the ASCII word "hello" (0x68 0x65 0x6C 0x6C 0x6F) one byte per accepted transfer, repeated a programmable number of times. It is the sending end of the hello byte stream and drives `data_out`/`data_out_valid` into the hello sequence detector. It also serves as the on-board stimulus source for that detector. An error-inject option corrupts the final byte so the negative path of the detector can be exercised.

## Interface
- `GAP_CYCLES`, default 0: idle cycles with valid low inserted after every accepted byte except the final byte of the run.
- `sys_clk` input, 1 bit: clock, all logic on the rising edge.
- `reset_n` input, 1 bit: reset, synchronous, active-low.
- `start` input, 1 bit: begin a run; sampled only in IDLE.
- `repeat_cnt` input, 8 bits: number of words per run, latched at start; 0 is treated as 1.
- `err_en` input, 1 bit: latched at start; when set, the last byte of the last word is 0x4F ("O") instead of 0x6F.
- `abort` input, 1 bit: synchronous run cancel.
- `data_out_ready` input, 1 bit: sink ready.
- `data_out` output, 8 bits: byte being offered.
- `data_out_valid` output, 1 bit: `data_out` is valid.
- `busy` output, 1 bit: run in progress.
- `done` output, 1 bit: one-cycle pulse when a run completes normally.
- `words_sent` output, 8 bits: number of complete words accepted in the current or last run.

## Operation
- States: IDLE, SEND_H, SEND_E, SEND_L1, SEND_L2, SEND_O, GAP. One-hot encoding; the GAP state records the return state.
- All outputs are registered.
- Reset values: `data_out` 0x00, `data_out_valid` 0, `busy` 0, `done` 0, `words_sent` 0, state IDLE.
- Transfer: a byte is accepted on a cycle where `data_out_valid` and `data_out_ready` are both high. While valid is high and not accepted, `data_out` is held stable.
- IDLE + `start`:
  - Latch `repeat_cnt` (0 becomes 1) and `err_en`.
  - Clear `words_sent`.
  - Go to SEND_H.
  - Assert `busy`.
- SEND_x states present their byte.
  - On acceptance, advance h→e→l1→l2→o. SEND_O advances to SEND_H of the next word.
  - When `GAP_CYCLES` > 0, the path goes through GAP. GAP holds valid low for exactly `GAP_CYCLES` cycles.
- Acceptance in SEND_O increments `words_sent` (saturates at 255; unreachable in practice).
- If that word was the last one, go to IDLE. `busy` drops and `done` pulses in that same next cycle. No trailing gap is inserted.
- `err_en` affects only the final byte of the final word. All earlier words are correct.
- `start` is ignored while `busy`. `start` in the cycle `done` is high (already IDLE) is accepted.
- `abort` in any non-IDLE state:
  - Next cycle: state IDLE, valid 0, `busy` 0, no `done` pulse.
  - If the same cycle also accepts a byte, that byte counts. `words_sent` increments if it was an "o".
- `reset_n` low mid-run: all outputs return to reset values on the next edge and the partial word is abandoned. Reset has priority over `abort` and `start`.

## Timing
- `start` high at cycle T (IDLE): valid high with 0x68 from T+1.
- With ready constantly high and `GAP_CYCLES`=0, one byte per cycle: T+1..T+5 carry h e l l o.
- For the same case, `done`=1 and `busy`=0 at T+6. `repeat_cnt`=N finishes at T+5N+1.
- With gap G: each non-final byte is followed by G valid-low cycles. A run of N words takes 5N + G(5N−1) cycles of valid-or-gap.
- Backpressure stalls the current state indefinitely. The gap counter starts only after acceptance.
- `done` is high for exactly one cycle. `busy` is high from T+1 through the final acceptance cycle.

## Test plan
- Single word: `repeat_cnt`=1, ready=1, G=0, start at T → bytes 68 65 6C 6C 6F at T+1..T+5; `done` at T+6; `words_sent`=1.
- Backpressure: ready low for 3 cycles while 0x65 is offered → 0x65 held stable with valid high; the sequence resumes unchanged; `done` is delayed by 3 cycles.
- Gap and repeat: G=2, `repeat_cnt`=3 → 15 bytes, each followed by 2 valid-low cycles except the last; `words_sent`=3; `done` after the final 0x6F.
- Error inject: `err_en`=1, `repeat_cnt`=2 → first word ends 0x6F, second ends 0x4F; a detector looped back asserts `check_ok` once only.
- Abort: abort raised while 0x6C(l1) is offered with ready=0 → valid 0 next cycle; no `done`; `words_sent` unchanged.
  - A second case raises abort together with acceptance of 0x6F → `words_sent` increments and no `done` pulses.
- Reset mid-run and start-while-busy:
  - `reset_n` low during SEND_L2 → all outputs at reset values next edge.
  - `start` pulsed while busy → ignored; a start coincident with `done` launches a new run.
